// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port among NUM_MASTERS masters,
// with a watchdog that aborts strobes the slave never acknowledges.
module wb_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADR_W       = 32,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_MASTERS-1:0]       M_CYC,
    input  logic [NUM_MASTERS-1:0]       M_STB,
    input  logic [NUM_MASTERS*ADR_W-1:0] M_ADR,
    output logic [NUM_MASTERS-1:0]       M_ACK,
    output logic [NUM_MASTERS-1:0]       M_ERR,
    output logic                         S_CYC,
    output logic                         S_STB,
    output logic [ADR_W-1:0]             S_ADR,
    input  logic                         S_ACK,
    output logic [NUM_MASTERS-1:0]       GNT
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       last_q, last_d;   // also the owner index while granted
    logic [WD_W-1:0]        wd_q, wd_d;

    logic             own_cyc;
    logic             own_stb;
    logic [ADR_W-1:0] own_adr;
    logic             wd_fire;
    logic             found;
    logic [IDX_W-1:0] cand;

    assign own_cyc = M_CYC[last_q];
    assign own_stb = M_STB[last_q];
    assign own_adr = M_ADR[32'(last_q) * ADR_W +: ADR_W];

    // Fires on the stalled cycle that would bring the count to TIMEOUT; a same-cycle ACK wins.
    assign wd_fire = (TIMEOUT > 0) && (state_q == ST_OWNED) && own_cyc && own_stb
                     && !S_ACK && (wd_q == WD_LAST);

    assign GNT = gnt_q;

    // Slave-side mux and master-side return paths; everything is zero unless OWNED.
    always_comb begin
        S_CYC = 1'b0;
        S_STB = 1'b0;
        S_ADR = '0;
        M_ACK = '0;
        M_ERR = '0;
        if (state_q == ST_OWNED) begin
            S_CYC         = own_cyc;
            S_STB         = own_stb;
            S_ADR         = own_adr;
            M_ACK[last_q] = S_ACK;
            M_ERR[last_q] = wd_fire;
        end
    end

    // Next-state, grant and watchdog update.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wd_d    = '0;
        found   = 1'b0;
        cand    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|M_CYC) begin
                    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
                        cand = IDX_W'((32'(last_q) + i) % NUM_MASTERS);
                        if (!found && M_CYC[cand]) begin
                            found  = 1'b1;
                            last_d = cand;
                        end
                    end
                    gnt_d         = '0;
                    gnt_d[last_d] = 1'b1;
                    state_d       = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!own_cyc) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (wd_fire) begin
                    state_d = ST_ABORT;
                end else if ((TIMEOUT > 0) && own_stb && !S_ACK) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_LAST;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (2 masters, TIMEOUT=4) with hand-computed expectations.
module tb_wb_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  M_CYC;
    logic [1:0]  M_STB;
    logic [63:0] M_ADR;
    logic [1:0]  M_ACK;
    logic [1:0]  M_ERR;
    logic        S_CYC;
    logic        S_STB;
    logic [31:0] S_ADR;
    logic        S_ACK;
    logic [1:0]  GNT;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(
        .NUM_MASTERS(2),
        .ADR_W      (32),
        .TIMEOUT    (4)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .M_CYC(M_CYC),
        .M_STB(M_STB),
        .M_ADR(M_ADR),
        .M_ACK(M_ACK),
        .M_ERR(M_ERR),
        .S_CYC(S_CYC),
        .S_STB(S_STB),
        .S_ADR(S_ADR),
        .S_ACK(S_ACK),
        .GNT  (GNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST   = 1'b1;
        M_CYC = 2'b00;
        M_STB = 2'b00;
        M_ADR = {32'h0000_2000, 32'h0000_1000};
        S_ACK = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 64'(GNT), 64'h0);
        chk("rst_scyc", 64'(S_CYC), 64'h0);
        chk("rst_mack", 64'(M_ACK), 64'h0);
        chk("rst_merr", 64'(M_ERR), 64'h0);
        RST = 1'b0;

        // Single master request, one-cycle grant latency, ACK routed to owner only
        tick();
        M_CYC = 2'b01;
        M_STB = 2'b01;
        #1;
        chk("t1_gnt_latency", 64'(GNT), 64'h0);
        tick();
        chk("t1_gnt", 64'(GNT), 64'h1);
        chk("t1_scyc", 64'(S_CYC), 64'h1);
        chk("t1_sstb", 64'(S_STB), 64'h1);
        chk("t1_sadr", 64'(S_ADR), 64'h1000);
        chk("t1_mack_idle", 64'(M_ACK), 64'h0);
        S_ACK = 1'b1;
        #1;
        chk("t1_mack", 64'(M_ACK), 64'h1);
        tick();
        S_ACK = 1'b0;
        M_CYC = 2'b00;
        M_STB = 2'b00;
        #1;
        chk("t1_gnt_hold", 64'(GNT), 64'h1);
        chk("t1_scyc_drop", 64'(S_CYC), 64'h0);
        tick();
        chk("t1_release", 64'(GNT), 64'h0);

        // Async reset while master 1 owns the bus
        M_CYC = 2'b10;
        M_STB = 2'b10;
        tick();
        chk("t6_gnt", 64'(GNT), 64'h2);
        chk("t6_sadr", 64'(S_ADR), 64'h2000);
        S_ACK = 1'b1;
        #1;
        chk("t6_mack", 64'(M_ACK), 64'h2);
        #1;
        RST = 1'b1;
        #1;
        chk("t6_async_gnt", 64'(GNT), 64'h0);
        chk("t6_async_scyc", 64'(S_CYC), 64'h0);
        chk("t6_async_mack", 64'(M_ACK), 64'h0);
        S_ACK = 1'b0;
        M_CYC = 2'b00;
        M_STB = 2'b00;
        tick();
        RST = 1'b0;

        // Simultaneous requests after reset: master 0 first, idle gap, then master 1
        M_CYC = 2'b11;
        tick();
        chk("t2_gnt_m0", 64'(GNT), 64'h1);
        M_CYC = 2'b10;
        tick();
        chk("t2_idle_gap", 64'(GNT), 64'h0);
        tick();
        chk("t2_gnt_m1", 64'(GNT), 64'h2);
        M_CYC = 2'b00;
        tick();
        chk("t2_release", 64'(GNT), 64'h0);
        M_CYC = 2'b11;
        tick();
        chk("t2_rr_m0", 64'(GNT), 64'h1);

        // No preemption: master 1 waits while master 0 keeps its cycle
        M_STB = 2'b11;
        S_ACK = 1'b1;
        #1;
        chk("t3_mack_owner", 64'(M_ACK), 64'h1);
        chk("t3_sadr", 64'(S_ADR), 64'h1000);
        tick();
        chk("t3_gnt_hold1", 64'(GNT), 64'h1);
        tick();
        chk("t3_gnt_hold2", 64'(GNT), 64'h1);
        chk("t3_mack_hold", 64'(M_ACK), 64'h1);
        M_CYC = 2'b10;
        M_STB = 2'b10;
        S_ACK = 1'b0;
        #1;
        chk("t3_mack_none", 64'(M_ACK), 64'h0);
        tick();
        chk("t3_idle_gap", 64'(GNT), 64'h0);
        tick();
        chk("t3_gnt_m1", 64'(GNT), 64'h2);

        // Watchdog abort: master 1 strobes with no ACK for 4 cycles
        chk("t4_c1_merr", 64'(M_ERR), 64'h0);
        chk("t4_c1_sstb", 64'(S_STB), 64'h1);
        tick();
        chk("t4_c2_merr", 64'(M_ERR), 64'h0);
        tick();
        chk("t4_c3_merr", 64'(M_ERR), 64'h0);
        tick();
        chk("t4_c4_merr", 64'(M_ERR), 64'h2);
        chk("t4_c4_scyc", 64'(S_CYC), 64'h1);
        tick();
        chk("t4_abort_merr", 64'(M_ERR), 64'h0);
        chk("t4_abort_scyc", 64'(S_CYC), 64'h0);
        chk("t4_abort_sstb", 64'(S_STB), 64'h0);
        chk("t4_abort_gnt", 64'(GNT), 64'h2);
        S_ACK = 1'b1;
        #1;
        chk("t4_abort_mack", 64'(M_ACK), 64'h0);
        S_ACK = 1'b0;
        tick();
        chk("t4_abort_wait", 64'(GNT), 64'h2);
        M_CYC = 2'b00;
        M_STB = 2'b00;
        tick();
        chk("t4_release", 64'(GNT), 64'h0);

        // ACK on the 4th stalled cycle beats the watchdog
        M_CYC = 2'b01;
        M_STB = 2'b01;
        tick();
        chk("t5_gnt", 64'(GNT), 64'h1);
        tick();
        tick();
        tick();
        S_ACK = 1'b1;
        #1;
        chk("t5_c4_merr", 64'(M_ERR), 64'h0);
        chk("t5_c4_mack", 64'(M_ACK), 64'h1);
        tick();
        S_ACK = 1'b0;
        #1;
        chk("t5_still_owned", 64'(S_CYC), 64'h1);
        chk("t5_merr_after", 64'(M_ERR), 64'h0);
        chk("t5_gnt_after", 64'(GNT), 64'h1);
        M_CYC = 2'b00;
        M_STB = 2'b00;
        tick();
        chk("t5_release", 64'(GNT), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
